// File: rtl/gecko_memory_stage_pkg.sv
// gecko_memory_stage_pkg: load/store types and the shared byte-lane formatting helpers
package gecko_memory_stage_pkg;
  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } rv32i_funct3_ls_t;
  typedef struct packed {
    logic             is_store;
    rv32i_funct3_ls_t op;
    logic [31:0]      addr;
    logic [31:0]      store_value;
    logic [4:0]       rd_addr;
    logic             speculative;
  } gecko_mem_request_t;
  typedef struct packed {
    logic [4:0]       rd_addr;
    rv32i_funct3_ls_t op;
    logic [1:0]       offset;
    logic             speculative;
  } gecko_load_tag_t;
  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  addr;
    logic        speculative;
  } gecko_operation_t;
  typedef struct packed {
    logic [31:0] value;
    logic [3:0]  mask;
  } gecko_store_result_t;
  function automatic logic is_half(rv32i_funct3_ls_t op);
    return op == LS_H || op == LS_HU;
  endfunction
  function automatic gecko_store_result_t gecko_get_store_result(logic [31:0] value, logic [1:0] offset,
                                                                 rv32i_funct3_ls_t op);
    gecko_store_result_t r;
    r.value = op == LS_W ? value : is_half(op) ? {2{value[15:0]}} : {4{value[7:0]}};
    r.mask  = op == LS_W ? 4'b1111 : is_half(op) ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b0001 << offset;
    return r;
  endfunction
  function automatic logic [31:0] gecko_get_load_result(logic [31:0] word, logic [1:0] offset,
                                                        rv32i_funct3_ls_t op);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    return op == LS_B  ? {{24{b[7]}}, b} :
           op == LS_BU ? {24'b0, b} :
           op == LS_H  ? {{16{h[15]}}, h} :
           op == LS_HU ? {16'b0, h} : word;
  endfunction
  function automatic logic gecko_is_misaligned(rv32i_funct3_ls_t op, logic [1:0] offset);
    return is_half(op) ? offset[0] : op == LS_W ? |offset : 1'b0;
  endfunction
endpackage

// File: rtl/gecko_memory_stage_if.sv
// gecko_memory_stage_if: request, memory command/response and writeback channels of the memory stage
interface gecko_memory_stage_if #(parameter int MAX_OUTSTANDING = 4);
  import gecko_memory_stage_pkg::*;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  logic               req_valid;
  logic               req_ready;
  gecko_mem_request_t req;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [31:0]        cmd_addr;
  logic               cmd_write;
  logic [3:0]         cmd_mask;
  logic [31:0]        cmd_data;
  logic               resp_valid;
  logic               resp_ready;
  logic [31:0]        resp_data;
  logic               wb_valid;
  logic               wb_ready;
  gecko_operation_t   wb;
  logic               misaligned;
  logic [CW-1:0]      outstanding;
  modport master (
    output req_valid, req, cmd_ready, resp_valid, resp_data, wb_ready,
    input  req_ready, cmd_valid, cmd_addr, cmd_write, cmd_mask, cmd_data,
           resp_ready, wb_valid, wb, misaligned, outstanding
  );
  modport slave (
    input  req_valid, req, cmd_ready, resp_valid, resp_data, wb_ready,
    output req_ready, cmd_valid, cmd_addr, cmd_write, cmd_mask, cmd_data,
           resp_ready, wb_valid, wb, misaligned, outstanding
  );
endinterface

// File: rtl/gecko_load_tracker.sv
// gecko_load_tracker: in-order FIFO of load tags awaiting their memory response
module gecko_load_tracker
  import gecko_memory_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  gecko_load_tag_t          push_tag,
  input  logic                     pop,
  output gecko_load_tag_t          head_tag,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  gecko_load_tag_t mem [DEPTH];
  logic [AW:0] wptr, rptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end
  // tag storage carries no reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_tag;
  end
  assign head_tag = mem[rptr[AW-1:0]];
  assign empty    = wptr == rptr;
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count    = wptr - rptr;
endmodule

// File: rtl/gecko_memory_stage.sv
// gecko_memory_stage: issues word-aligned memory commands and formats in-order load writebacks
module gecko_memory_stage
  import gecko_memory_stage_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  gecko_memory_stage_if.slave  bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  logic                cmd_valid, cmd_write, wb_valid, misaligned;
  logic [31:0]         cmd_addr, cmd_data;
  logic [3:0]          cmd_mask;
  gecko_operation_t    wb_r;
  logic                accept, issue, mis, push, pop, empty, full, resp_ready;
  logic [CW-1:0]       count;
  gecko_load_tag_t     head;
  gecko_store_result_t st;
  assign mis        = gecko_is_misaligned(bus.req.op, bus.req.addr[1:0]);
  assign st         = gecko_get_store_result(bus.req.store_value, bus.req.addr[1:0], bus.req.op);
  assign bus.req_ready = (!cmd_valid || bus.cmd_ready) && (bus.req.is_store || !full);
  assign accept     = bus.req_valid && bus.req_ready;
  assign issue      = accept && !mis;
  assign push       = issue && !bus.req.is_store;
  assign resp_ready = !empty && (!wb_valid || bus.wb_ready);
  assign pop        = bus.resp_valid && resp_ready;
  gecko_load_tracker #(.DEPTH(MAX_OUTSTANDING)) tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_tag ('{rd_addr: bus.req.rd_addr, op: bus.req.op, offset: bus.req.addr[1:0],
                 speculative: bus.req.speculative}),
    .pop      (pop),
    .head_tag (head),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_write <= 1'b0;
      cmd_mask  <= '0;
      cmd_data  <= '0;
    end else if (issue) begin
      cmd_valid <= 1'b1;
      cmd_addr  <= {bus.req.addr[31:2], 2'b00};
      cmd_write <= bus.req.is_store;
      cmd_mask  <= bus.req.is_store ? st.mask : 4'b0000;
      cmd_data  <= bus.req.is_store ? st.value : 32'b0;
    end else if (bus.cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned <= 1'b0;
    else misaligned <= accept && mis;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_r     <= '0;
    end else if (pop) begin
      wb_valid <= 1'b1;
      wb_r     <= '{value: gecko_get_load_result(bus.resp_data, head.offset, head.op),
                    addr: head.rd_addr, speculative: head.speculative};
    end else if (bus.wb_ready) begin
      wb_valid <= 1'b0;
    end
  end
  assign bus.cmd_valid   = cmd_valid;
  assign bus.cmd_addr    = cmd_addr;
  assign bus.cmd_write   = cmd_write;
  assign bus.cmd_mask    = cmd_mask;
  assign bus.cmd_data    = cmd_data;
  assign bus.resp_ready  = resp_ready;
  assign bus.wb_valid    = wb_valid;
  assign bus.wb          = wb_r;
  assign bus.misaligned  = misaligned;
  assign bus.outstanding = count;
  // a response with no load in flight is a memory-side protocol violation
  resp_without_load: assert property (@(posedge clk) disable iff (!rst_n) !(bus.resp_valid && empty));
  push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
endmodule
